// File: rtl/ram_pkg.sv
// Shared encodings for the ram_moc_ctrl memory slice: access sizes, R/W sense
// and FSM state constants.
package ram_pkg;

    typedef logic [1:0] size_t;
    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'b00;
    localparam state_t WAIT = 2'b01;
    localparam state_t DONE = 2'b10;

endpackage

// File: rtl/ram_moc_ctrl_if.sv
// Enable/MOC request bus between the control unit (master) and the memory (slave).
interface ram_moc_ctrl_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              Enable;
    logic              ReadWrite;
    logic [1:0]        Size;
    logic              SignExt;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MOC;
    logic              Misalign;

    modport master (
        output Enable, ReadWrite, Size, SignExt, Address, DataIn,
        input  DataOut, MOC, Misalign
    );

    modport slave (
        input  Enable, ReadWrite, Size, SignExt, Address, DataIn,
        output DataOut, MOC, Misalign
    );
endinterface

// File: rtl/ram_align_unit.sv
// Combinational size/alignment logic: misalignment flag, big-endian byte-lane
// write enables/data and load justification with optional sign extension.
module ram_align_unit
    import ram_pkg::*;
(
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] din,
    input  logic [31:0] raw,
    output logic        misalign,
    output logic [3:0]  lane_we,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    // Lane 3 (bits 31:24) is the byte at the access address, lane 0 is A+3.
    always_comb begin
        misalign   = 1'b0;
        lane_we    = '0;
        lane_wdata = '0;
        load_data  = '0;
        case (size)
            SZ_BYTE: begin
                lane_we    = 4'b1000;
                lane_wdata = {din[7:0], 24'h0};
                load_data  = {{24{sign_ext & raw[31]}}, raw[31:24]};
            end
            SZ_HALF: begin
                misalign   = addr_lo[0];
                lane_we    = 4'b1100;
                lane_wdata = {din[15:0], 16'h0};
                load_data  = {{16{sign_ext & raw[31]}}, raw[31:16]};
            end
            default: begin
                misalign   = (addr_lo != 2'b00);
                lane_we    = 4'b1111;
                lane_wdata = din;
                load_data  = raw;
            end
        endcase
        if (misalign)
            lane_we = '0;
    end

endmodule

// File: rtl/ram_moc_ctrl.sv
// Byte-addressable big-endian memory with Enable/MOC handshake and wait states.
module ram_moc_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter              INIT_FILE   = "ramdata.txt"
) (
  input  logic           CLK,
  input  logic           reset,
  ram_moc_ctrl_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_din;
  size_t             l_size;
  logic              l_sext;
  logic              l_rw;
  logic [31:0]       dout_q;
  logic              mis_q;

  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_din;
  size_t             a_size;
  logic              a_sext;
  logic              a_rw;
  logic              access;
  logic [31:0]       raw;
  logic              au_mis;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;

  // With zero wait states the access happens on the sampling edge, so the
  // live bus fields are used instead of the (not yet loaded) latches.
  always_comb begin
    if (state == IDLE) begin
      a_addr = bus.Address;
      a_din  = bus.DataIn;
      a_size = bus.Size;
      a_sext = bus.SignExt;
      a_rw   = bus.ReadWrite;
    end else begin
      a_addr = l_addr;
      a_din  = l_din;
      a_size = l_size;
      a_sext = l_sext;
      a_rw   = l_rw;
    end
    if (WAIT_CYCLES == 0)
      access = (state == IDLE) && bus.Enable;
    else
      access = (state == WAIT) && bus.Enable && (cnt == 4'd0);
    raw = '0;
    for (int unsigned i = 0; i < 4; i++)
      raw[31-8*i -: 8] = mem[a_addr + ADDR_W'(i)];
  end

  ram_align_unit u_align (
    .size       (a_size),
    .sign_ext   (a_sext),
    .addr_lo    (a_addr[1:0]),
    .din        (a_din),
    .raw        (raw),
    .misalign   (au_mis),
    .lane_we    (lane_we),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      l_addr <= '0;
      l_din  <= '0;
      l_size <= SZ_BYTE;
      l_sext <= 1'b0;
      l_rw   <= RW_READ;
      dout_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Enable) begin
          l_addr <= bus.Address;
          l_din  <= bus.DataIn;
          l_size <= bus.Size;
          l_sext <= bus.SignExt;
          l_rw   <= bus.ReadWrite;
          cnt    <= 4'(WAIT_CYCLES);
          state  <= (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          if (!bus.Enable)
            state <= IDLE;
          else if (cnt == 4'd0)
            state <= DONE;
          else
            cnt <= cnt - 4'd1;
        end
        DONE: if (!bus.Enable)
          state <= IDLE;
        default: state <= IDLE;
      endcase
      if (access) begin
        mis_q <= au_mis;
        if (a_rw == RW_READ && !au_mis)
          dout_q <= load_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset && access && a_rw == RW_WRITE) begin
      for (int unsigned i = 0; i < 4; i++)
        if (lane_we[3-i])
          mem[a_addr + ADDR_W'(i)] <= lane_wdata[31-8*i -: 8];
    end
  end

  assign bus.DataOut  = dout_q;
  assign bus.MOC      = (state == DONE);
  assign bus.Misalign = mis_q;

endmodule

// File: tb/tb_ram_moc_ctrl.sv
// Directed bench for ram_moc_ctrl: one instance with 1 wait state, one with 3.
module tb_ram_moc_ctrl;

    logic CLK;
    logic reset;
    int   n_pass;
    int   n_total;

    ram_moc_ctrl_if #(.ADDR_W(9)) bus1();
    ram_moc_ctrl_if #(.ADDR_W(9)) bus3();

    ram_moc_ctrl #(.ADDR_W(9), .WAIT_CYCLES(1), .INIT_FILE("ramdata.txt")) dut1 (
        .CLK(CLK), .reset(reset), .bus(bus1)
    );
    ram_moc_ctrl #(.ADDR_W(9), .WAIT_CYCLES(3), .INIT_FILE("ramdata.txt")) dut3 (
        .CLK(CLK), .reset(reset), .bus(bus3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        sx;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_d;
        logic        exp_m;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input bit sel, input logic en, input logic rw, input logic [1:0] sz,
                         input logic sx, input logic [8:0] a, input logic [31:0] d);
        if (sel) begin
            bus3.Enable = en; bus3.ReadWrite = rw; bus3.Size = sz;
            bus3.SignExt = sx; bus3.Address = a; bus3.DataIn = d;
        end else begin
            bus1.Enable = en; bus1.ReadWrite = rw; bus1.Size = sz;
            bus1.SignExt = sx; bus1.Address = a; bus1.DataIn = d;
        end
    endtask

    function automatic logic moc(input bit sel);
        return sel ? bus3.MOC : bus1.MOC;
    endfunction

    task automatic set_en(input bit sel, input logic en);
        if (sel) bus3.Enable = en; else bus1.Enable = en;
    endtask

    // Starts just after a rising edge; returns edges from sampling edge to MOC.
    task automatic wait_moc(input bit sel, output int lat);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge CLK); #1;
            n++;
            if (moc(sel) === 1'b1) seen = 1;
        end
        lat = seen ? n - 1 : -1;
    endtask

    task automatic do_op(input bit sel, input logic rw, input logic [1:0] sz, input logic sx,
                         input logic [8:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] dq, output logic mq,
                         output logic mo_after);
        drive(sel, 1'b1, rw, sz, sx, a, d);
        wait_moc(sel, lat);
        dq = sel ? bus3.DataOut : bus1.DataOut;
        mq = sel ? bus3.Misalign : bus1.Misalign;
        set_en(sel, 1'b0);
        @(posedge CLK); #1;
        mo_after = moc(sel);
    endtask

    initial begin
        int          lat;
        logic [31:0] dq;
        logic        mq;
        logic        mo;
        logic        seen;

        n_pass = 0;
        n_total = 0;

        vt[0]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 2'b00, 1'b1, 9'h010, 32'h0,        32'hFFFFFFDE, 1'b0};
        vt[3]  = '{1'b1, 2'b00, 1'b0, 9'h010, 32'h0,        32'h000000DE, 1'b0};
        vt[4]  = '{1'b1, 2'b01, 1'b1, 9'h012, 32'h0,        32'hFFFFBEEF, 1'b0};
        vt[5]  = '{1'b0, 2'b00, 1'b0, 9'h011, 32'h0000005A, 32'hFFFFBEEF, 1'b0};
        vt[6]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDE5ABEEF, 1'b0};
        vt[7]  = '{1'b1, 2'b10, 1'b0, 9'h013, 32'h0,        32'hDE5ABEEF, 1'b1};
        vt[8]  = '{1'b0, 2'b01, 1'b0, 9'h011, 32'h00001234, 32'hDE5ABEEF, 1'b1};
        vt[9]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDE5ABEEF, 1'b0};
        vt[10] = '{1'b1, 2'b01, 1'b0, 9'h010, 32'h0,        32'h0000DE5A, 1'b0};
        vt[11] = '{1'b1, 2'b00, 1'b1, 9'h013, 32'h0,        32'hFFFFFFEF, 1'b0};
        vt[12] = '{1'b1, 2'b11, 1'b0, 9'h012, 32'h0,        32'hFFFFFFEF, 1'b1};
        vt[13] = '{1'b1, 2'b11, 1'b0, 9'h010, 32'h0,        32'hDE5ABEEF, 1'b0};
        vt[14] = '{1'b0, 2'b01, 1'b0, 9'h016, 32'hFFFF8001, 32'hDE5ABEEF, 1'b0};
        vt[15] = '{1'b1, 2'b01, 1'b1, 9'h016, 32'h0,        32'hFFFF8001, 1'b0};
        vt[16] = '{1'b1, 2'b00, 1'b1, 9'h017, 32'h0,        32'h00000001, 1'b0};
        vt[17] = '{1'b1, 2'b01, 1'b0, 9'h016, 32'h0,        32'h00008001, 1'b0};
        vt[18] = '{1'b0, 2'b10, 1'b0, 9'h1FC, 32'hCAFEF00D, 32'h00008001, 1'b0};
        vt[19] = '{1'b1, 2'b10, 1'b0, 9'h1FC, 32'h0,        32'hCAFEF00D, 1'b0};
        vt[20] = '{1'b1, 2'b00, 1'b1, 9'h1FF, 32'h0,        32'h0000000D, 1'b0};
        vt[21] = '{1'b1, 2'b00, 1'b1, 9'h1FE, 32'h0,        32'hFFFFFFF0, 1'b0};

        drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 9'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 9'h0, 32'h0);
        reset = 1'b0;
        #2;
        chk("reset moc1",  32'(bus1.MOC),      32'd0);
        chk("reset dout1", bus1.DataOut,       32'd0);
        chk("reset mis1",  32'(bus1.Misalign), 32'd0);
        chk("reset moc3",  32'(bus3.MOC),      32'd0);
        chk("reset dout3", bus3.DataOut,       32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < NV; i++) begin
            do_op(1'b0, vt[i].rw, vt[i].sz, vt[i].sx, vt[i].addr, vt[i].din, lat, dq, mq, mo);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d dout", i), dq, vt[i].exp_d);
            chk($sformatf("v%0d misalign", i), 32'(mq), 32'(vt[i].exp_m));
            chk($sformatf("v%0d moc drop", i), 32'(mo), 32'd0);
        end

        // Handshake hold, with bus fields changed after they were latched.
        drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 9'h030, 32'h01020304);
        @(posedge CLK); #1;
        bus1.DataIn = 32'hFFFFFFFF;
        bus1.Address = 9'h034;
        wait_moc(1'b0, lat);
        chk("hold latency", 32'(lat + 1), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("hold moc c%0d", k), 32'(bus1.MOC), 32'd1);
        end
        bus1.Enable = 1'b0;
        chk("hold moc before drop edge", 32'(bus1.MOC), 32'd1);
        @(posedge CLK); #1;
        chk("hold moc drop", 32'(bus1.MOC), 32'd0);
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 9'h030, 32'h0, lat, dq, mq, mo);
        chk("hold reload", dq, 32'h01020304);

        // Three wait states: baseline store, then an aborted overwrite.
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'hAABBCCDD, lat, dq, mq, mo);
        chk("w3 store latency", 32'(lat), 32'd4);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'h11223344);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus3.Enable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            if (bus3.MOC !== 1'b0) seen = 1'b1;
        end
        chk("abort moc", 32'(seen), 32'd0);
        do_op(1'b1, 1'b1, 2'b10, 1'b0, 9'h020, 32'h0, lat, dq, mq, mo);
        chk("abort load latency", 32'(lat), 32'd4);
        chk("abort word kept", dq, 32'hAABBCCDD);

        // Reset asserted while a store sits in WAIT.
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'h99999999);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b0;
        #1;
        chk("midreset moc",  32'(bus3.MOC), 32'd0);
        chk("midreset dout", bus3.DataOut,  32'd0);
        bus3.Enable = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        do_op(1'b1, 1'b1, 2'b10, 1'b0, 9'h020, 32'h0, lat, dq, mq, mo);
        chk("midreset word kept", dq, 32'hAABBCCDD);
        chk("midreset load latency", 32'(lat), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
